// File: rtl/face_tx_pkg.sv
// rtl/face_tx_pkg.sv - shared types and helpers for the face detection UART return path
// FACE_TX_CHECKSUM_EN adds a trailing XOR byte to every detection packet.
package face_tx_pkg;

    typedef struct packed {
        logic [3:0]  pyramid;
        logic [15:0] row;
        logic [15:0] col;
    } face_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_EOF,
        START,
        DATA,
        STOP
    } tx_state_e;

`ifdef FACE_TX_CHECKSUM_EN
    localparam int PKT_BYTES = 7;
`else
    localparam int PKT_BYTES = 6;
`endif

    // Coordinates wider than 16 bits clamp to all-ones so the host can spot them.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (|v[31:16]) ? 16'hFFFF : v[15:0];
    endfunction

`ifdef FACE_TX_CHECKSUM_EN
    function automatic logic [7:0] pkt_checksum(input face_entry_t e);
        return {4'h0, e.pyramid} ^ e.row[15:8] ^ e.row[7:0] ^ e.col[15:8] ^ e.col[7:0];
    endfunction
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer with a valid/ready byte input
// tready also rises in the last stop-bit cycle so consecutive bytes go out without a gap.
module uart_byte_tx
    import face_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tdata_i,
    input  logic       tvalid_i,
    output logic       tready_o,
    output logic       tx_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e      state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           baud_last;

    always_comb begin
        baud_last = (baud_q == BAUD_LAST);
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tready_o  = 1'b0;
        case (state_q)
            IDLE: begin
                tready_o = 1'b1;
                if (tvalid_i) begin
                    shift_d = tdata_i;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    tready_o = 1'b1;
                    if (tvalid_i) begin
                        shift_d = tdata_i;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        baud_d = (state_q == IDLE || baud_last) ? '0 : baud_q + BW'(1);
        // tx is registered from the next state so the line never glitches.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/face_coords_tx.sv
// rtl/face_coords_tx.sv - queues face detections and frames them as UART packets plus end-of-frame
// FACE_TX_CHECKSUM_EN appends an XOR byte to each detection packet.
module face_coords_tx
    import face_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter logic [7:0] EOF_BYTE     = 8'h5A
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0][31:0]              face_coords,
    input  logic                          face_coords_ready,
    input  logic [3:0]                    pyramid_number,
    input  logic                          scan_done,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    face_entry_t    mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_q, rd_q;
    logic           ready_prev_q, overflow_q, eof_q;
    tx_state_e      state_q, state_d;
    face_entry_t    pkt_q, pkt_d;
    logic [2:0]     byte_idx_q, byte_idx_d, nbytes_q, nbytes_d;

    logic           push, push_ok, pop, full, empty, eof_clr;
    logic [7:0]     ser_tdata;
    logic           ser_tvalid, ser_tready;
    face_entry_t    head, entry;

    function automatic logic [7:0] pkt_byte(input face_entry_t e, input logic [2:0] idx);
        case (idx)
            3'd1:    return {4'h0, e.pyramid};
            3'd2:    return e.row[15:8];
            3'd3:    return e.row[7:0];
            3'd4:    return e.col[15:8];
            3'd5:    return e.col[7:0];
`ifdef FACE_TX_CHECKSUM_EN
            3'd6:    return pkt_checksum(e);
`endif
            default: return HDR_BYTE;
        endcase
    endfunction

    assign fifo_count = wr_q - rd_q;
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    assign empty      = (fifo_count == '0);
    assign head       = mem_q[rd_q[AW-1:0]];
    assign entry      = '{pyramid: pyramid_number, row: sat16(face_coords[0]), col: sat16(face_coords[1])};
    assign push       = face_coords_ready & ~ready_prev_q;
    // A simultaneous pop frees the slot, so a full FIFO still accepts that push.
    assign push_ok    = push & (~full | pop);
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;

    // START here spans the whole byte run; bit-level phases live in uart_byte_tx.
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        byte_idx_d = byte_idx_q;
        nbytes_d   = nbytes_q;
        pop        = 1'b0;
        eof_clr    = 1'b0;
        ser_tvalid = 1'b0;
        ser_tdata  = pkt_byte(pkt_q, byte_idx_q);
        case (state_q)
            IDLE: begin
                if (!empty)     state_d = LOAD;
                else if (eof_q) state_d = LOAD_EOF;
            end
            LOAD: begin
                ser_tvalid = 1'b1;
                ser_tdata  = HDR_BYTE;
                if (ser_tready) begin
                    pop        = 1'b1;
                    pkt_d      = head;
                    byte_idx_d = 3'd1;
                    nbytes_d   = 3'(PKT_BYTES);
                    state_d    = START;
                end
            end
            LOAD_EOF: begin
                ser_tvalid = 1'b1;
                ser_tdata  = EOF_BYTE;
                if (ser_tready) begin
                    eof_clr    = 1'b1;
                    byte_idx_d = 3'd1;
                    nbytes_d   = 3'd1;
                    state_d    = START;
                end
            end
            START: begin
                if (byte_idx_q != nbytes_q) begin
                    ser_tvalid = 1'b1;
                    if (ser_tready) byte_idx_d = byte_idx_q + 3'd1;
                end else if (ser_tready) begin
                    if (!empty) begin
                        ser_tvalid = 1'b1;
                        ser_tdata  = HDR_BYTE;
                        pop        = 1'b1;
                        pkt_d      = head;
                        byte_idx_d = 3'd1;
                        nbytes_d   = 3'(PKT_BYTES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pkt_q        <= '0;
            byte_idx_q   <= 3'd0;
            nbytes_q     <= 3'd0;
            wr_q         <= '0;
            rd_q         <= '0;
            ready_prev_q <= 1'b0;
            overflow_q   <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_q        <= pkt_d;
            byte_idx_q   <= byte_idx_d;
            nbytes_q     <= nbytes_d;
            ready_prev_q <= face_coords_ready;
            overflow_q   <= overflow_q | (push & ~push_ok);
            eof_q        <= eof_clr ? 1'b0 : (eof_q | scan_done);
            if (push_ok) wr_q <= wr_q + CW'(1);
            if (pop)     rd_q <= rd_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= entry;
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clock    (clock),
        .reset    (reset),
        .tdata_i  (ser_tdata),
        .tvalid_i (ser_tvalid),
        .tready_o (ser_tready),
        .tx_o     (tx)
    );

endmodule

// File: doc/face_coords_tx.md
Name: face_coords_tx

Overview:
- Return path of the laptop link. Takes face detections produced by the detection pipeline (face_coords, face_coords_ready, pyramid_number) and an end-of-scan indication.
- Buffers detections in a small FIFO, frames each one as a fixed byte packet and serializes it as UART 8N1 on `tx` back to the laptop.
- After the scan finishes and all queued packets are out, sends a single end-of-frame byte so the host knows the image is complete.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, detection entries buffered; power of two >= 2.
- HDR_BYTE, 8'hA5, first byte of every detection packet.
- EOF_BYTE, 8'h5A, end-of-frame byte.

Ports:
- clock  in  1  system clock
- reset  in  1  async, active-high
- face_coords  in  [1:0][31:0]  [0]=row index, [1]=col index of the detected window's top-left corner
- face_coords_ready  in  1  level from the pipeline, synchronous to clock; each rising edge = one detection
- pyramid_number  in  4  pyramid level of the detection; sampled together with face_coords
- scan_done  in  1  one-cycle pulse: all windows of the current image have been sent
- tx  out  1  UART serial out, idle high
- busy  out  1  high whenever the FSM is not IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
- overflow  out  1  sticky: at least one detection was dropped

Behaviour:
- Reset values:
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - FSM in IDLE, eof_pending=0, ready_prev=0.
  - Reset mid-byte truncates the frame immediately (tx forced high asynchronously) and flushes the FIFO.
- Push:
  - push = face_coords_ready & ~ready_prev.
  - On push, the entry {pyramid_number, row16, col16} is written at that edge.
  - row16/col16 saturate: if bits [31:16] are nonzero, the value becomes 16'hFFFF; otherwise it is bits [15:0].
- FIFO full:
  - A push to a full FIFO is dropped and sets overflow; overflow clears only on reset.
  - Push and pop in the same cycle are both honoured, fifo_count unchanged; full+push+pop is accepted, not dropped.
- Packet format, 6 bytes:
  - HDR_BYTE, {4'h0,pyramid}, row[15:8], row[7:0], col[15:8], col[7:0].
  - Each byte goes out LSB first as start(0), 8 data bits, stop(1), each bit held for exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes or between back-to-back packets.
- FSM states:
  - IDLE:
    - FIFO non-empty -> LOAD.
    - Else if eof_pending -> LOAD_EOF.
    - Else stay.
  - LOAD: pop the FIFO head into the 48-bit packet register, byte_idx=0, nbytes=6 -> START.
  - LOAD_EOF: load EOF_BYTE, nbytes=1, clear eof_pending -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
  - DATA: tx=shift[bit_idx]; after CLKS_PER_BIT cycles bit_idx++; after bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; then byte_idx++. If byte_idx<nbytes -> START with the next byte, else -> IDLE.
- Latency:
  - The push edge is N; the FSM enters LOAD at N+1 and START at N+2.
  - tx falls in the cycle after edge N+2.
  - A full 6-byte packet occupies 60*CLKS_PER_BIT cycles from the tx fall to the end of the last stop bit.
- scan_done and end-of-frame:
  - scan_done sets eof_pending.
  - A further scan_done while pending is ignored: one EOF only.
  - EOF is sent only when the FIFO is empty and the FSM is in IDLE, so it always follows every detection pushed before or during the scan_done cycle.
  - scan_done coincident with a push: the push is queued and EOF goes out after it.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is only cleared on state entry.

Optional Feature:
- Macro FACE_TX_CHECKSUM_EN.
- When defined:
  - A 7th byte is appended to every detection packet: the XOR of bytes 1..5 (header excluded); nbytes=7.
  - EOF stays a single byte.
  - Packet time becomes 70*CLKS_PER_BIT.
- When undefined: exactly 6 bytes, no checksum logic.

Decomposition:
- Package face_tx_pkg holds:
  - typedef face_entry_t (packed: pyramid[3:0], row[15:0], col[15:0]).
  - typedef tx_state_e (IDLE, LOAD, LOAD_EOF, START, DATA, STOP).
  - PKT_BYTES constant (6 or 7 depending on FACE_TX_CHECKSUM_EN).
- Sub-module uart_byte_tx: byte-in/valid/ready handshake, START/DATA/STOP serializer with baud counter.
  - face_coords_tx keeps the FIFO, edge detect, packet sequencing and EOF logic.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Single detection: row=16, col=32, pyramid=2 -> tx decodes A5 02 00 10 00 20; tx falls 2 cycles after the push edge; busy drops 240 cycles later.
- Saturation: row=32'h12345, col=32'h7 -> bytes A5 xx FF FF 00 07.
- Overflow: 11 pushes every 2 cycles while the first packet is being sent -> the FIFO reaches 8 entries, overflow=1, exactly 9 packets transmitted in push order, overflow still 1 afterwards.
- EOF ordering: 3 pushes then scan_done, plus a second scan_done 10 cycles later -> 3 packets, then a single 5A, then idle.
- FACE_TX_CHECKSUM_EN defined with row=16, col=32, pyramid=2 -> 7th byte 02^00^10^00^20=32; packet lasts 280 cycles.
- Reset asserted mid-DATA of byte 3 with 2 entries queued -> tx=1 immediately, fifo_count=0, busy=0; no bytes appear after reset release until a new push.
